// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one main-memory port between the I-cache (port 0) and D-cache (port 1).
// Round-robin on ties, fixed memory latency, one-cycle stop pulse per completed access.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start0,
    input  logic            start1,
    input  logic [31:0]     addr0,
    input  logic [31:0]     addr1,
    input  logic            we0,
    input  logic            we1,
    input  logic [3:0][7:0] wdata0,
    input  logic [3:0][7:0] wdata1,
    output logic            stop0,
    output logic            stop1,
    output logic [3:0][7:0] rdata0,
    output logic [3:0][7:0] rdata1,
    output logic [31:0]     mem_addr,
    output logic            mem_we,
    output logic [3:0][7:0] mem_data_in,
    input  logic [3:0][7:0] mem_data_out,
    output logic            busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [7:0] CNT_INIT = 8'(MEM_LATENCY - 1);

    logic [1:0]      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            gnt_q, gnt_d;
    logic            rd_q, rd_d;
    logic            stop0_q, stop0_d, stop1_q, stop1_d;
    logic [3:0][7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [31:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [3:0][7:0] wdata_q, wdata_d;
    logic            busy_q, busy_d;
    logic            win;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        rd_d     = rd_q;
        stop0_d  = stop0_q;
        stop1_d  = stop1_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        // On a tie the port that did not win last time goes next.
        win      = (start0 && start1) ? ~last_q : start1;
        case (state_q)
            IDLE: begin
                if (start0 || start1) begin
                    gnt_d   = win;
                    last_d  = win;
                    addr_d  = win ? addr1 : addr0;
                    wdata_d = win ? wdata1 : wdata0;
                    we_d    = win ? we1 : we0;
                    rd_d    = ~(win ? we1 : we0);
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                we_d = 1'b0;
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    if (rd_q) begin
                        if (gnt_q) rdata1_d = mem_data_out;
                        else       rdata0_d = mem_data_out;
                    end
                    stop0_d = ~gnt_q;
                    stop1_d = gnt_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                stop0_d = 1'b0;
                stop1_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            rd_q     <= 1'b0;
            stop0_q  <= 1'b0;
            stop1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            rd_q     <= rd_d;
            stop0_q  <= stop0_d;
            stop1_q  <= stop1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
        end
    end

    assign stop0       = stop0_q;
    assign stop1       = stop1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign mem_addr    = addr_q;
    assign mem_we      = we_q;
    assign mem_data_in = wdata_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected completions are queued at issue time and
// checked by a monitor on every stop pulse; a second instance covers MEM_LATENCY=1.
module tb_mem_port_arbiter;
    localparam int LAT = 4;

    typedef struct {
        logic        port;
        logic        rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // ---------------- instance A: MEM_LATENCY = 4 ----------------
    logic        start0, start1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        stop0, stop1, mem_we, busy;
    logic [31:0] rdata0, rdata1, mem_addr, mem_data_in;
    logic [31:0] mem_dout = '0;

    mem_port_arbiter #(.MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .start0(start0), .start1(start1),
        .addr0(addr0), .addr1(addr1),
        .we0(we0), .we1(we1),
        .wdata0(wdata0), .wdata1(wdata1),
        .stop0(stop0), .stop1(stop1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_data_in(mem_data_in), .mem_data_out(mem_dout),
        .busy(busy)
    );

    // ---------------- instance B: MEM_LATENCY = 1 ----------------
    logic        start0_b;
    logic        stop0_b, stop1_b, mem_we_b, busy_b;
    logic [31:0] rdata0_b, rdata1_b, mem_addr_b, mem_data_in_b;
    logic [31:0] mem_dout_b = '0;
    logic [31:0] addr0_b;

    mem_port_arbiter #(.MEM_LATENCY(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .start0(start0_b), .start1(1'b0),
        .addr0(addr0_b), .addr1(32'h0),
        .we0(1'b0), .we1(1'b0),
        .wdata0(32'h0), .wdata1(32'h0),
        .stop0(stop0_b), .stop1(stop1_b),
        .rdata0(rdata0_b), .rdata1(rdata1_b),
        .mem_addr(mem_addr_b), .mem_we(mem_we_b),
        .mem_data_in(mem_data_in_b), .mem_data_out(mem_dout_b),
        .busy(busy_b)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [16];
    logic [15:0] wr_vld = '0;

    function automatic logic [3:0] idx(input logic [31:0] a);
        return a[15:12] ^ a[11:8];
    endfunction

    function automatic logic [31:0] preload(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'hDEAD_BEEF;
            32'h0000_3000: return 32'hA5A5_1234;
            default:       return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return wr_vld[idx(a)] ? mem[idx(a)] : preload(a);
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            mem[idx(mem_addr)]    <= mem_data_in;
            wr_vld[idx(mem_addr)] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        mem_dout   <= rd(mem_addr);
        mem_dout_b <= mem_addr_b ^ 32'hA5A5_A5A5;
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    exp_t exp_q[$];
    exp_t e;
    int   we_cnt = 0;
    int   busy_cnt = 0;
    logic [31:0] we_addr = '0;

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = mem_addr;
        end
        if (busy) busy_cnt = busy_cnt + 1;
        if (stop0 || stop1) begin
            chk("stop_overlap", {31'b0, stop0 & stop1}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_stop", {stop1, stop0}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("grant_port", {31'b0, stop1}, {31'b0, e.port});
                chk("stop_cycle", cyc, e.cyc);
                if (e.rd) chk("rdata", e.port ? rdata1 : rdata0, e.data);
            end
        end
    end

    task automatic push(input logic p, input logic r, input logic [31:0] d, input int c);
        exp_t x;
        x.port = p; x.rd = r; x.data = d; x.cyc = c;
        exp_q.push_back(x);
    endtask

    // Waits for the stop of port p, then drops that port's start inside the DONE cycle.
    task automatic wait_done(input logic p);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (p ? stop1 : stop0) got = 1'b1;
        end
        chk(p ? "done1_timeout" : "done0_timeout", {31'b0, got}, 32'd1);
        if (p) start1 = 1'b0;
        else   start0 = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int c;
        bit got;
        reset = 1'b0;
        start0 = 0; start1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        start0_b = 0; addr0_b = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_stops", {30'b0, stop1, stop0}, 32'h0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_mem_data_in", mem_data_in, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single read on port 0
        c = cyc;
        push(1'b0, 1'b1, 32'hDEAD_BEEF, c + 1 + LAT);
        we_cnt = 0; busy_cnt = 0;
        addr0 = 32'h100; we0 = 1'b0; start0 = 1'b1;
        wait_done(1'b0);
        repeat (2) @(negedge clk);
        chk("read_no_we", we_cnt, 32'd0);
        chk("read_busy_cycles", busy_cnt, LAT + 1);

        // 2: write on port 1, then read it back on port 0
        c = cyc;
        push(1'b1, 1'b0, 32'h0, c + 1 + LAT);
        we_cnt = 0;
        addr1 = 32'h2000; we1 = 1'b1; wdata1 = 32'h1234_5678; start1 = 1'b1;
        wait_done(1'b1);
        repeat (2) @(negedge clk);
        chk("write_we_cycles", we_cnt, 32'd1);
        chk("write_we_addr", we_addr, 32'h2000);
        chk("write_rdata1_kept", rdata1, 32'h0);
        c = cyc;
        push(1'b0, 1'b1, 32'h1234_5678, c + 1 + LAT);
        addr0 = 32'h2000; start0 = 1'b1;
        wait_done(1'b0);
        @(negedge clk);

        // 3: tie right after reset, both ports re-request -> 0,1,0,1
        pulse_reset();
        we1 = 1'b0; addr0 = 32'h100; addr1 = 32'h2000;
        c = cyc;
        push(1'b0, 1'b1, 32'hDEAD_BEEF, c + 1 + LAT);
        push(1'b1, 1'b1, 32'h1234_5678, c + 1 + LAT + (LAT + 2));
        push(1'b0, 1'b1, 32'hDEAD_BEEF, c + 1 + LAT + 2 * (LAT + 2));
        push(1'b1, 1'b1, 32'h1234_5678, c + 1 + LAT + 3 * (LAT + 2));
        fork
            begin
                for (int k = 0; k < 2; k++) begin
                    start0 = 1'b1;
                    wait_done(1'b0);
                    @(negedge clk);
                end
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    start1 = 1'b1;
                    wait_done(1'b1);
                    @(negedge clk);
                end
            end
        join
        repeat (2) @(negedge clk);

        // 4: port 1 requests while port 0 is mid-access
        c = cyc;
        push(1'b0, 1'b1, 32'hDEAD_BEEF, c + 1 + LAT);
        push(1'b1, 1'b1, 32'hA5A5_1234, c + 1 + LAT + (LAT + 2));
        addr0 = 32'h100; start0 = 1'b1;
        repeat (2) @(negedge clk);
        addr1 = 32'h3000; start1 = 1'b1;
        repeat (3) @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        chk("overlap_addr_idle", mem_addr, 32'h100);
        @(negedge clk);
        chk("overlap_addr_p1", mem_addr, 32'h3000);
        wait_done(1'b1);
        repeat (2) @(negedge clk);

        // 5: reset during the second ACCESS cycle
        addr0 = 32'h100; start0 = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_rdata0", rdata0, 32'h0);
        chk("midrst_mem_we", {31'b0, mem_we}, 32'h0);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_stop", exp_q.size(), 32'd0);
        c = cyc;
        push(1'b0, 1'b1, 32'hDEAD_BEEF, c + 1 + LAT);
        start0 = 1'b1;
        wait_done(1'b0);
        repeat (2) @(negedge clk);

        // 6: MEM_LATENCY = 1 instance
        c = cyc;
        addr0_b = 32'h4444_0010; start0_b = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (stop0_b) got = 1'b1;
        end
        chk("lat1_timeout", {31'b0, got}, 32'd1);
        chk("lat1_stop_cycle", cyc, c + 2);
        chk("lat1_rdata", rdata0_b, 32'hE1E1_A5B5);
        start0_b = 1'b0;
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
